dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory address width.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter LEN_W, default 4, host burst-length field width; burst beats = H_Len+1.
REQ-004 Clock  in  1  single system clock; all state changes on the rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 C_Req, C_Wr  in  1 each  CPU controller access request and write flag.
REQ-007 C_Addr  in  ADDR_W  CPU address; C_WData  in  DATA_W  CPU write data.
REQ-008 C_Gnt, C_Done  out  1 each  CPU grant pulse and completion pulse.
REQ-009 C_RData  out  DATA_W  CPU read data, valid while C_Done=1.
REQ-010 H_Req, H_Wr  in  1 each  host/debug-loader request and write flag.
REQ-011 H_Addr  in  ADDR_W  host start address; H_Len  in  LEN_W  beats minus one.
REQ-012 H_WData  in  DATA_W  host write data, sampled per beat.
REQ-013 H_Gnt, H_Done  out  1 each  host grant pulse and per-beat completion pulse.
REQ-014 H_RData  out  DATA_W  host read data, valid while H_Done=1.
REQ-015 M_Addr  out  ADDR_W; M_Wr  out  1; M_WData  out  DATA_W; M_RData  in  DATA_W; memory has one-cycle registered read.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; one-hot or binary encoding is permitted.
REQ-017 IDLE: at an edge with any Req high, latch winner's Wr/Addr/WData (host: also Len) and go to ACCESS; otherwise stay in IDLE.
REQ-018 Arbitration is round-robin: when both Reqs are high, the winner is the requester not granted last; a single requester always wins.
REQ-019 The winner's Gnt is high for exactly the first ACCESS cycle of the transaction.
REQ-020 ACCESS: drive M_Addr=current address and M_Wr=latched Wr; M_WData=latched data (host: H_WData sampled in this cycle); then go to RESP.
REQ-021 RESP: M_Wr=0; winner's Done=1; winner's RData=M_RData (reads and writes both pulse Done).
REQ-022 RESP exit: if beats remain, increment the address modulo 2^ADDR_W (0xFF->0x00), decrement the beat count, go to ACCESS; otherwise go to IDLE.
REQ-023 CPU transactions are always one beat; a host burst is never interrupted by C_Req.
REQ-024 Latency: Req sampled at edge k -> Gnt in cycle k..k+1 -> Done in cycle k+1..k+2; single beat occupies 2 cycles plus 1 IDLE cycle.
REQ-025 A requester holding Req through its Done cycle is treated as a new request at the next IDLE edge.
REQ-026 M_Wr is never high outside ACCESS; the non-winner's Gnt/Done remain 0 throughout.
REQ-027 Inputs changing after latch (except H_WData) do not affect an in-flight transaction.

Reset
REQ-028 Reset low forces IDLE immediately, independent of Clock.
REQ-029 During reset all outputs are 0; M_Wr=0 within the same cycle.
REQ-030 After reset, last-grant = host, so CPU wins the first simultaneous request.
REQ-031 Reset mid-burst aborts remaining beats; no Done is issued for aborted beats.

Structure
REQ-032 State enum and ADDR_W/DATA_W defaults live in the shared processor package.
REQ-033 No sub-module is required; the round-robin pick is a combinational block inside dmem_arbiter.

Verification
REQ-034 CPU read: C_Req=1, C_Addr=0x0B, M_RData=0x1234 -> C_Gnt one cycle, C_Done next cycle with C_RData=0x1234, M_Wr=0 throughout.
REQ-035 Simultaneous C_Req and H_Req right after reset -> CPU granted first, then host at the next IDLE; then both again -> CPU granted (alternation).
REQ-036 Host write burst H_Addr=0xFE, H_Len=3, H_WData=0xA0..0xA3 -> M_Wr pulses at 0xFE,0xFF,0x00,0x01 with matching data; four H_Done pulses; one H_Gnt.
REQ-037 C_Req asserted during host burst -> C_Gnt only after final H_Done, no CPU access interleaved.
REQ-038 Reset low during second beat of a 4-beat host read -> all outputs 0 immediately, no further H_Done; IDLE after release.
REQ-039 CPU write C_Addr=0xCD, C_WData=0x00FF -> one M_Wr cycle at 0xCD with 0x00FF, C_Done next cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared processor types and width defaults for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin CPU/host arbiter for a single-port data memory
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              C_Req,
  input  logic              C_Wr,
  input  logic [ADDR_W-1:0] C_Addr,
  input  logic [DATA_W-1:0] C_WData,
  output logic              C_Gnt,
  output logic              C_Done,
  output logic [DATA_W-1:0] C_RData,
  input  logic              H_Req,
  input  logic              H_Wr,
  input  logic [ADDR_W-1:0] H_Addr,
  input  logic [LEN_W-1:0]  H_Len,
  input  logic [DATA_W-1:0] H_WData,
  output logic              H_Gnt,
  output logic              H_Done,
  output logic [DATA_W-1:0] H_RData,
  output logic [ADDR_W-1:0] M_Addr,
  output logic              M_Wr,
  output logic [DATA_W-1:0] M_WData,
  input  logic [DATA_W-1:0] M_RData
);

  arb_state_t        state_q, state_d;
  logic              host_q;       // current transaction belongs to the host
  logic              last_host_q;  // most recent grant went to the host
  logic              first_q;      // next ACCESS is the first beat of the transaction
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W-1:0]  beats_q;      // beats remaining after the current one
  logic              pick_host;
  logic              more_beats;

  assign more_beats = host_q && (beats_q != '0);

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    pick_host = 1'b0;
    if (H_Req && (!C_Req || !last_host_q)) begin
      pick_host = 1'b1;
    end
  end

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory/handshake outputs; everything idles at zero
  always_comb begin
    state_d = state_q;
    C_Gnt   = 1'b0;
    C_Done  = 1'b0;
    C_RData = '0;
    H_Gnt   = 1'b0;
    H_Done  = 1'b0;
    H_RData = '0;
    M_Addr  = '0;
    M_Wr    = 1'b0;
    M_WData = '0;
    case (state_q)
      ST_IDLE: begin
        if (C_Req || H_Req) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        M_Addr  = addr_q;
        M_Wr    = wr_q;
        // host data streams live per beat, CPU data was captured at the grant
        M_WData = host_q ? H_WData : wdata_q;
        C_Gnt   = first_q && !host_q;
        H_Gnt   = first_q && host_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        C_Done  = !host_q;
        H_Done  = host_q;
        C_RData = host_q ? '0 : M_RData;
        H_RData = host_q ? M_RData : '0;
        state_d = more_beats ? ST_ACCESS : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transaction context: latched at the grant edge, advanced between burst beats
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      host_q      <= 1'b0;
      last_host_q <= 1'b1;
      first_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beats_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (C_Req || H_Req) begin
            host_q      <= pick_host;
            last_host_q <= pick_host;
            first_q     <= 1'b1;
            wr_q        <= pick_host ? H_Wr : C_Wr;
            addr_q      <= pick_host ? H_Addr : C_Addr;
            wdata_q     <= pick_host ? '0 : C_WData;
            beats_q     <= pick_host ? H_Len : '0;
          end
        end
        ST_ACCESS: begin
          first_q <= 1'b0;
        end
        ST_RESP: begin
          if (more_beats) begin
            addr_q  <= addr_q + 1'b1;
            beats_q <= beats_q - 1'b1;
          end
        end
        default: begin
          first_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          C_Req = 1'b0, C_Wr = 1'b0;
  logic [AW-1:0] C_Addr = '0;
  logic [DW-1:0] C_WData = '0;
  logic          C_Gnt, C_Done;
  logic [DW-1:0] C_RData;
  logic          H_Req = 1'b0, H_Wr = 1'b0;
  logic [AW-1:0] H_Addr = '0;
  logic [LW-1:0] H_Len = '0;
  logic [DW-1:0] H_WData = '0;
  logic          H_Gnt, H_Done;
  logic [DW-1:0] H_RData;
  logic [AW-1:0] M_Addr;
  logic          M_Wr;
  logic [DW-1:0] M_WData;
  logic [DW-1:0] M_RData = '0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .Clock(Clock), .Reset(Reset),
    .C_Req(C_Req), .C_Wr(C_Wr), .C_Addr(C_Addr), .C_WData(C_WData),
    .C_Gnt(C_Gnt), .C_Done(C_Done), .C_RData(C_RData),
    .H_Req(H_Req), .H_Wr(H_Wr), .H_Addr(H_Addr), .H_Len(H_Len), .H_WData(H_WData),
    .H_Gnt(H_Gnt), .H_Done(H_Done), .H_RData(H_RData),
    .M_Addr(M_Addr), .M_Wr(M_Wr), .M_WData(M_WData), .M_RData(M_RData)
  );

  always #5 Clock = ~Clock;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 'h0B) return 16'h1234;
    return DW'(i * 16'h0101) ^ 16'h5A5A;
  endfunction

  // Memory model: one-cycle registered read, read returns the old word on a write
  logic [DW-1:0] mem [256];
  bit            loaded = 1'b0;
  always @(posedge Clock) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else begin
      M_RData <= mem[M_Addr];
      if (M_Wr) mem[M_Addr] <= M_WData;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] shadow [256];
  logic          exp_gnt [$];
  logic [63:0]   exp_wr  [$];
  logic [DW-1:0] exp_cd  [$];
  logic [DW-1:0] exp_hd  [$];
  int            h_left = 0;
  int            h_len_next = 0;

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge Clock) begin
    if (Reset) begin
      if (C_Gnt || H_Gnt) begin
        check("gnt_excl", {63'b0, C_Gnt & H_Gnt}, 64'd0);
        if (exp_gnt.size() == 0) check("gnt_unexp", 64'd1, 64'd0);
        else check("gnt_who", {63'b0, H_Gnt}, {63'b0, exp_gnt.pop_front()});
        if (C_Gnt) check("cgnt_in_burst", 64'(h_left), 64'd0);
        if (H_Gnt) h_left = h_len_next;
      end
      if (M_Wr) begin
        if (exp_wr.size() == 0) check("wr_unexp", {40'b0, M_Addr, M_WData}, 64'd0);
        else check("wr_addr_data", {40'b0, M_Addr, M_WData}, exp_wr.pop_front());
      end
      if (C_Done) begin
        check("done_excl", {63'b0, H_Done}, 64'd0);
        if (exp_cd.size() == 0) check("cdone_unexp", 64'd1, 64'd0);
        else check("c_rdata", 64'(C_RData), 64'(exp_cd.pop_front()));
      end
      if (H_Done) begin
        if (exp_hd.size() == 0) check("hdone_unexp", 64'd1, 64'd0);
        else check("h_rdata", 64'(H_RData), 64'(exp_hd.pop_front()));
        if (h_left > 0) h_left = h_left - 1;
      end
    end
  end

  task automatic cpu_expect(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_gnt.push_back(1'b0);
    if (wr) exp_wr.push_back({40'b0, a, d});
    exp_cd.push_back(shadow[a]);
    if (wr) shadow[a] = d;
  endtask

  task automatic host_expect(input logic wr, input logic [AW-1:0] a, input int nbeats,
                             input logic [DW-1:0] base);
    logic [AW-1:0] aa;
    logic [DW-1:0] d;
    exp_gnt.push_back(1'b1);
    for (int i = 0; i < nbeats; i++) begin
      aa = a + AW'(i);
      d  = base + DW'(i);
      if (wr) exp_wr.push_back({40'b0, aa, d});
      exp_hd.push_back(shadow[aa]);
      if (wr) shadow[aa] = d;
    end
  endtask

  task automatic cpu_drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    @(posedge Clock); #1;
    C_Req = 1'b1; C_Wr = wr; C_Addr = a; C_WData = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clock);
      got = C_Gnt;
    end
    C_Req = 1'b0;
    if (!got) begin
      check("c_gnt_timeout", 64'd0, 64'd1);
      return;
    end
    C_Wr = ~wr; C_Addr = AW'($urandom); C_WData = DW'($urandom);
    @(negedge Clock);
    check("c_gnt_len", {63'b0, C_Gnt}, 64'd0);
    check("c_done_lat", {63'b0, C_Done}, 64'd1);
    @(negedge Clock);
    check("c_done_len", {63'b0, C_Done}, 64'd0);
  endtask

  task automatic host_drive(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len,
                            input logic [DW-1:0] base, input int nwait);
    bit got = 0;
    H_WData = base;
    @(posedge Clock); #1;
    h_len_next = int'(len) + 1;
    H_Req = 1'b1; H_Wr = wr; H_Addr = a; H_Len = len;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clock);
      got = H_Gnt;
    end
    H_Req = 1'b0;
    if (!got) begin
      check("h_gnt_timeout", 64'd0, 64'd1);
      return;
    end
    H_Wr = ~wr; H_Addr = AW'($urandom); H_Len = LW'($urandom);
    for (int b = 0; b < nwait; b++) begin
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge Clock);
        got = H_Done;
      end
      if (!got) begin
        check("h_done_timeout", 64'd0, 64'd1);
        return;
      end
      #1 H_WData = base + DW'(b + 1);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {3'b0, C_Gnt, C_Done, C_RData, H_Gnt, H_Done, H_RData, M_Addr, M_Wr, M_WData};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    repeat (3) @(negedge Clock);
    check("rst_outputs", all_outs(), 64'd0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // simultaneous requests after reset: CPU, host, then CPU again
    cpu_expect(1'b0, 8'h10, '0);
    host_expect(1'b0, 8'h20, 2, '0);
    fork
      cpu_drive(1'b0, 8'h10, '0);
      host_drive(1'b0, 8'h20, 4'd1, '0, 2);
    join
    cpu_expect(1'b0, 8'h11, '0);
    host_expect(1'b0, 8'h30, 1, '0);
    fork
      cpu_drive(1'b0, 8'h11, '0);
      host_drive(1'b0, 8'h30, 4'd0, '0, 1);
    join

    // CPU read and write
    cpu_expect(1'b0, 8'h0B, '0);
    cpu_drive(1'b0, 8'h0B, '0);
    cpu_expect(1'b1, 8'hCD, 16'h00FF);
    cpu_drive(1'b1, 8'hCD, 16'h00FF);
    cpu_expect(1'b0, 8'hCD, '0);
    cpu_drive(1'b0, 8'hCD, '0);

    // wrapping host write burst with a CPU request arriving mid-burst
    host_expect(1'b1, 8'hFE, 4, 16'h00A0);
    cpu_expect(1'b0, 8'hFF, '0);
    fork
      host_drive(1'b1, 8'hFE, 4'd3, 16'h00A0, 4);
      begin
        repeat (3) @(posedge Clock);
        cpu_drive(1'b0, 8'hFF, '0);
      end
    join
    host_expect(1'b0, 8'h00, 2, '0);
    host_drive(1'b0, 8'h00, 4'd1, '0, 2);

    // reset during the second beat of a 4-beat host read
    host_expect(1'b0, 8'h40, 1, '0);
    host_drive(1'b0, 8'h40, 4'd3, '0, 1);
    @(negedge Clock);
    check("abort_beat2_addr", {56'b0, M_Addr}, 64'h41);
    #1 Reset = 1'b0;
    #1 check("abort_outputs", all_outs(), 64'd0);
    h_left = 0;
    @(negedge Clock);
    check("abort_hold", all_outs(), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (6) @(negedge Clock);

    // reset restores CPU priority on a tie
    cpu_expect(1'b1, 8'h50, 16'hBEEF);
    host_expect(1'b0, 8'h50, 1, '0);
    fork
      cpu_drive(1'b1, 8'h50, 16'hBEEF);
      host_drive(1'b0, 8'h50, 4'd0, '0, 1);
    join

    repeat (4) @(negedge Clock);
    check("sb_empty", 64'(exp_gnt.size() + exp_wr.size() + exp_cd.size() + exp_hd.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
